// File: rtl/nrisc_ula_arb.sv
// Two-port round-robin front end for the shared NRISC ULA. It accepts one operation at a time
// and runs shift/rotate ops as repeated single-bit passes fed back through the ULA.
module nrisc_ula_arb #(
   parameter int TAM = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [3:0]     req0_ctrl,
   input  logic [TAM-1:0] req0_a,
   input  logic [TAM-1:0] req0_b,
   input  logic [3:0]     req0_cnt,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [3:0]     req1_ctrl,
   input  logic [TAM-1:0] req1_a,
   input  logic [TAM-1:0] req1_b,
   input  logic [3:0]     req1_cnt,
   output logic           resp0_valid,
   output logic [TAM-1:0] resp0_data,
   output logic [2:0]     resp0_flags,
   output logic           resp1_valid,
   output logic [TAM-1:0] resp1_data,
   output logic [2:0]     resp1_flags,
   output logic [TAM-1:0] ula_a,
   output logic [TAM-1:0] ula_b,
   output logic [3:0]     ula_ctrl,
   input  logic [TAM-1:0] ula_out,
   input  logic [2:0]     ula_flags
);

   // state | meaning
   // IDLE  | arbitrate and accept one request
   // RUN   | one ULA pass per cycle, result fed back into acc
   // DONE  | one-cycle response pulse to the owner
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_next;
   logic           last_grant, owner;
   logic [3:0]     op_ctrl, rem;
   logic [TAM-1:0] acc, b_reg;
   logic [2:0]     flags_reg;

   logic           win1, accept, is_shift, zero_cnt;
   logic [3:0]     sel_ctrl, sel_cnt;
   logic [TAM-1:0] sel_a, sel_b;

   always_comb begin
      // On a tie, the port that was not served last wins.
      win1       = req1_valid && (!req0_valid || !last_grant);
      sel_ctrl   = win1 ? req1_ctrl : req0_ctrl;
      sel_a      = win1 ? req1_a    : req0_a;
      sel_b      = win1 ? req1_b    : req0_b;
      sel_cnt    = win1 ? req1_cnt  : req0_cnt;
      accept     = !rst && (state == IDLE) && (req0_valid || req1_valid);
      req0_ready = accept && !win1;
      req1_ready = accept && win1;
      is_shift   = (sel_ctrl[2:0] == 3'b101) || (sel_ctrl[2:0] == 3'b110);
      zero_cnt   = is_shift && (sel_cnt == 4'd0);
   end

   always_comb begin
      ula_a      = '0;
      ula_b      = '0;
      ula_ctrl   = 4'd0;
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = zero_cnt ? DONE : RUN;
         RUN: begin
            ula_a    = acc;
            ula_b    = b_reg;
            ula_ctrl = op_ctrl;
            if (rem <= 4'd1) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         owner       <= 1'b0;
         op_ctrl     <= 4'd0;
         acc         <= '0;
         b_reg       <= '0;
         rem         <= 4'd0;
         flags_reg   <= 3'b000;
         resp0_valid <= 1'b0;
         resp0_data  <= '0;
         resp0_flags <= 3'b000;
         resp1_valid <= 1'b0;
         resp1_data  <= '0;
         resp1_flags <= 3'b000;
      end else begin
         state       <= state_next;
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               owner   <= win1;
               op_ctrl <= sel_ctrl;
               acc     <= sel_a;
               b_reg   <= sel_b;
               rem     <= is_shift ? sel_cnt : 4'd1;
               // Zero-count shift: the response is registered here, no ULA pass.
               if (zero_cnt) begin
                  flags_reg <= 3'b000;
                  if (win1) begin
                     resp1_valid <= 1'b1;
                     resp1_data  <= sel_a;
                     resp1_flags <= 3'b000;
                  end else begin
                     resp0_valid <= 1'b1;
                     resp0_data  <= sel_a;
                     resp0_flags <= 3'b000;
                  end
               end
            end
            RUN: begin
               acc       <= ula_out;
               flags_reg <= ula_flags;
               rem       <= rem - 4'd1;
               // Response registers load with the last pass so they are valid in DONE.
               if (state_next == DONE) begin
                  if (owner) begin
                     resp1_valid <= 1'b1;
                     resp1_data  <= ula_out;
                     resp1_flags <= ula_flags;
                  end else begin
                     resp0_valid <= 1'b1;
                     resp0_data  <= ula_out;
                     resp0_flags <= ula_flags;
                  end
               end
            end
            DONE:    last_grant <= owner;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/nrisc_ula_arb.md
# nrisc_ula_arb

Two-port arbiter and sequencer for the NRISC ULA. It shares the single combinational ULA between two requesters, for example the execute stage and the address/auxiliary path. It accepts one operation at a time using round-robin priority. Shift and rotate operations are expanded into N single-bit ULA passes by feeding the result back. It returns the registered result and flags to the requester that issued the operation.

## Interface
Parameters:
- TAM, 16: datapath width; must match the ULA instance.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid / req1_valid  in  1  operation request from requester 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_ctrl / req1_ctrl  in  4  ULA command {cmd, ctrla}
  - ctrla: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shift/rotate right, 110 shift/rotate left, 111 not
  - cmd: 1 = rotate, 0 = shift
- req0_a / req1_a  in  TAM  operand A
- req0_b / req1_b  in  TAM  operand B
- req0_cnt / req1_cnt  in  4  bit count; used only for ctrla 101/110
- resp0_valid / resp1_valid  out  1  one-cycle result pulse
- resp0_data / resp1_data  out  TAM  result; held until the next response to the same port
- resp0_flags / resp1_flags  out  3  {minus, zero, carry}, taken unchanged from the ULA's last pass
- ula_a  out  TAM  to ULA_A
- ula_b  out  TAM  to ULA_B
- ula_ctrl  out  4  to ULA_ctrl
- ula_out  in  TAM  from ULA_OUT; combinational in the same cycle
- ula_flags  in  3  from ULA_flags; combinational in the same cycle

## Operation
States: IDLE, RUN, DONE.

IDLE:
- ula_a, ula_b and ula_ctrl are driven to 0.
- reqX_ready is combinational: it is 1 only for the port selected by arbitration, and only when that port's valid is 1.
- Arbitration:
  - If only one valid is asserted, that port wins.
  - If both are asserted, the port other than last_grant wins.
- On acceptance:
  - latch ctrl, a, b and cnt into op_ctrl, acc, b_reg and rem; latch the winner into owner.
  - Passes: shift/rotate ops use rem = cnt; all other ops use rem = 1.
  - Next state:
    - Shift/rotate with cnt = 0: go to DONE with acc = A and flags_reg = 3'b000. No ULA pass is made.
    - Otherwise: go to RUN.

RUN:
- Drive ula_a = acc, ula_b = b_reg, ula_ctrl = op_ctrl.
- Each cycle: acc <= ula_out, flags_reg <= ula_flags, rem <= rem - 1.
- When rem = 1, go to DONE.
- Both requests are ignored and both ready signals are 0.

DONE:
- respOWNER_valid = 1 for one cycle; respOWNER_data = acc; respOWNER_flags = flags_reg.
- The other port's resp outputs are unchanged.
- last_grant <= owner; next state is IDLE.
- No request is accepted in this cycle.

Other rules:
- Widths: rem is 4 bits, so there are at most 15 passes. No arithmetic is done here; all arithmetic is in the ULA.
- A requester holds valid and its operands until it sees ready. Deasserting valid before ready is legal; that request is simply not taken.

Reset (asynchronous, any state):
- state = IDLE; last_grant = 1, so port 0 wins the first tie.
- owner = 0; acc, b_reg, rem and flags_reg = 0.
- All resp data and flags = 0; all valid and ready = 0.
- An in-flight operation is discarded and no response is produced.

## Timing
- Accept at cycle T (ready high in IDLE).
- Cycles T+1 to T+N are ULA passes, where N = cnt for shift/rotate and N = 1 otherwise.
- resp valid is high in cycle T+N+1.
- The next accept is at T+N+2 at the earliest.
- Shift/rotate with cnt = 0: resp valid at T+1; next accept at T+2.
- Throughput for single-pass ops: one operation every 3 cycles.
- ready is combinational from valid and state. All other outputs are registered.

## Test plan
Use a behavioral ULA model that matches the command encoding and returns fixed flags per op.

- Add: req0 ctrl 4'b0000, A = 16'h1234, B = 16'h0001 at T. Required: ready0 at T; ula_ctrl = 0000 at T+1; resp0_valid at T+2 with data 16'h1235; resp1_valid stays 0.
- Multi-pass shift left: req1 ctrl 4'b0110, A = 16'h0F0F, cnt = 4. Required: ula_ctrl = 0110 for 4 cycles, with ula_a stepping 0F0F, 1E1E, 3C3C, 7878; resp1 data 16'hF0F0 at T+5.
- Rotate right, cnt = 1: ctrl 4'b1101, A = 16'h0001. Required: resp data 16'h8000 at T+2; flags equal the model's flags from that pass.
- Simultaneous requests after reset: req0 and req1 both valid. Required:
  - port 0 granted first;
  - req1 accepted in the IDLE cycle after resp0;
  - if a third tie follows that, port 0 wins again, confirming round-robin.
- Zero-count shift: ctrl 4'b0101, cnt = 0, A = 16'hABCD. Required: resp valid at T+1 with data 16'hABCD and flags 000; no ULA pass (ula_ctrl stays 0).
- Reset during RUN: assert rst in cycle 2 of an 8-pass shift. Required: outputs clear immediately, no resp pulse, and a later request is served with port 0 priority.
